dispensador_troco: RTL and testbench

//  Change-coin dispenser: consumes the per-denomination change vector produced by the

---
 rtl/dispensador_troco.sv | 133 +++++++++++++
 tb/tb_dispensador_troco.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dispensador_troco.sv
// Change-coin dispenser: ejects coins one at a time from three hoppers using a
// drive-pulse / drop-sensor handshake, largest denomination first.
module dispensador_troco #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_moedas,
  output logic [2:0]  hopper_pulso,
  input  logic [2:0]  sensor_moeda,
  output logic        done,
  output logic        erro,
  output logic [15:0] valor_entregue,
  output logic [23:0] moedas_pendentes
);

  // state  | meaning
  // IDLE   | ready for a request
  // SELECT | pick largest denomination still owed
  // PULSE  | drive the selected hopper
  // WAIT   | hopper released, waiting for the drop sensor
  // DONE   | one-cycle completion pulse
  // ERRO   | one-cycle sensor-timeout pulse
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] PULSE  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERRO   = 3'd5;

  localparam int PCW = $clog2(PULSE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LOAD   = TCW'(TIMEOUT_CYCLES - 1);

  logic [2:0]     state;
  logic [2:0]     sel;
  logic [2:0]     next_sel;
  logic [PCW-1:0] pulse_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic [23:0]    pend_next;
  logic [15:0]    val_add;
  logic           coin_hit;

  // sel is kept one-hot so it doubles as the hopper drive and sensor mask
  assign coin_hit     = (|(sensor_moeda & sel)) && (state == PULSE || state == WAIT);
  assign req_ready    = (state == IDLE);
  assign done         = (state == DONE);
  assign erro         = (state == ERRO);
  assign hopper_pulso = (state == PULSE) ? sel : 3'b000;

  always_comb begin
    next_sel = 3'b000;
    if (moedas_pendentes[23:16] != 8'd0)     next_sel = 3'b100;
    else if (moedas_pendentes[15:8] != 8'd0) next_sel = 3'b010;
    else if (moedas_pendentes[7:0] != 8'd0)  next_sel = 3'b001;
  end

  always_comb begin
    pend_next = moedas_pendentes;
    val_add   = 16'd0;
    case (sel)
      3'b001: if (moedas_pendentes[7:0] != 8'd0) begin
        pend_next[7:0] = moedas_pendentes[7:0] - 8'd1;
        val_add        = 16'd25;
      end
      3'b010: if (moedas_pendentes[15:8] != 8'd0) begin
        pend_next[15:8] = moedas_pendentes[15:8] - 8'd1;
        val_add         = 16'd50;
      end
      3'b100: if (moedas_pendentes[23:16] != 8'd0) begin
        pend_next[23:16] = moedas_pendentes[23:16] - 8'd1;
        val_add          = 16'd100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      sel              <= 3'b000;
      pulse_cnt        <= '0;
      tmo_cnt          <= '0;
      valor_entregue   <= 16'd0;
      moedas_pendentes <= 24'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          moedas_pendentes <= req_moedas;
          valor_entregue   <= 16'd0;
          state            <= SELECT;
        end
        SELECT: begin
          sel       <= next_sel;
          pulse_cnt <= PULSE_LOAD;
          tmo_cnt   <= TMO_LOAD;
          state     <= (next_sel == 3'b000) ? DONE : PULSE;
        end
        PULSE: begin
          if (coin_hit) begin
            moedas_pendentes <= pend_next;
            valor_entregue   <= valor_entregue + val_add;
            state            <= SELECT;
          end else if (pulse_cnt == '0) begin
            tmo_cnt <= TMO_LOAD;
            state   <= WAIT;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        WAIT: begin
          if (coin_hit) begin
            moedas_pendentes <= pend_next;
            valor_entregue   <= valor_entregue + val_add;
            state            <= SELECT;
          end else if (tmo_cnt == '0) begin
            state <= ERRO;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERRO:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dispensador_troco.sv
// Directed bench for dispensador_troco: scripted sensor responses, hopper
// activity monitor and hand-computed expectations.
module tb_dispensador_troco;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_moedas;
  logic [2:0]  hopper_pulso;
  logic [2:0]  sensor_moeda;
  logic        done;
  logic        erro;
  logic [15:0] valor_entregue;
  logic [23:0] moedas_pendentes;

  dispensador_troco #(.PULSE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_moedas       (req_moedas),
    .hopper_pulso     (hopper_pulso),
    .sensor_moeda     (sensor_moeda),
    .done             (done),
    .erro             (erro),
    .valor_entregue   (valor_entregue),
    .moedas_pendentes (moedas_pendentes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          mode = 0;
  int          hop_cycles = 0;
  int          done_cnt = 0;
  int          erro_cnt = 0;
  int          run = 0;
  int          pend_cnt = 0;
  int          k = 0;
  logic [2:0]  prev_hop = 3'b000;
  logic [2:0]  pend_bit = 3'b000;
  logic [11:0] order = 12'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    hop_cycles = 0; done_cnt = 0; erro_cnt = 0; order = 12'd0;
    run = 0; pend_cnt = 0;
  endtask

  // One clock: sample at the falling edge, then drive the sensor for the next rising edge.
  // mode 1: sensor 2 clk after each pulse ends; 2: bit1 every 5 clk; 3: sensor in 2nd pulse clk
  task automatic step();
    @(negedge clock);
    cyc++;
    if (hopper_pulso != 3'b000) begin
      hop_cycles++;
      if (hopper_pulso != prev_hop) order = (order << 3) | {9'd0, hopper_pulso};
      run = (hopper_pulso == prev_hop) ? run + 1 : 1;
    end else begin
      run = 0;
    end
    done_cnt += int'(done);
    erro_cnt += int'(erro);
    sensor_moeda = 3'b000;
    case (mode)
      1: begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) sensor_moeda = pend_bit;
        end
        if (hopper_pulso == 3'b000 && prev_hop != 3'b000) begin
          pend_bit = prev_hop;
          pend_cnt = 2;
        end
      end
      2: if (cyc % 5 == 0) sensor_moeda = 3'b010;
      3: if (run == 2) sensor_moeda = hopper_pulso;
      default: ;
    endcase
    prev_hop = hopper_pulso;
  endtask

  task automatic accept(input logic [23:0] m);
    req_moedas = m;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic wait_end(input int max_cycles, output int n);
    n = 0;
    while (!(done || erro) && n < max_cycles) begin
      step();
      n++;
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_moedas = 24'd0; sensor_moeda = 3'b000;
    step(); step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_hopper", 32'(hopper_pulso), 32'd0);
    chk("rst_done_erro", {30'd0, done, erro}, 32'd0);
    chk("rst_valor", 32'(valor_entregue), 32'd0);
    chk("rst_pend", 32'(moedas_pendentes), 32'd0);
    reset_n = 1'b1;
    step();

    // 1: one coin of each, sensor after each pulse
    clr_mon(); mode = 1;
    accept(24'h010101);
    chk("t1_ready_busy", 32'(req_ready), 32'd0);
    wait_end(200, k);
    chk("t1_ended", 32'(done), 32'd1);
    chk("t1_order", 32'(order), 32'h111);
    chk("t1_hop_cycles", 32'(hop_cycles), 32'd12);
    chk("t1_valor", 32'(valor_entregue), 32'd175);
    chk("t1_pend", 32'(moedas_pendentes), 32'd0);
    step();
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_ready_after", 32'(req_ready), 32'd1);

    // 2: zero request, done two clocks after accept
    clr_mon(); mode = 0;
    accept(24'h000000);
    wait_end(20, k);
    chk("t2_latency", 32'(k), 32'd1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_hop_cycles", 32'(hop_cycles), 32'd0);
    chk("t2_valor", 32'(valor_entregue), 32'd0);
    step();

    // 3: no sensor for the 1,00 coin -> timeout
    clr_mon(); mode = 0;
    accept(24'h010002);
    wait_end(2000, k);
    chk("t3_latency", 32'(k), 32'd1005);
    chk("t3_erro", 32'(erro), 32'd1);
    chk("t3_pend", 32'(moedas_pendentes), 32'h010002);
    chk("t3_valor", 32'(valor_entregue), 32'd0);
    chk("t3_order", 32'(order), 32'h004);
    chk("t3_hop_cycles", 32'(hop_cycles), 32'd4);
    step();
    chk("t3_erro_cnt", 32'(erro_cnt), 32'd1);
    chk("t3_done_cnt", 32'(done_cnt), 32'd0);
    chk("t3_ready_after", 32'(req_ready), 32'd1);
    chk("t3_pend_hold", 32'(moedas_pendentes), 32'h010002);

    // 4: sensor on the wrong bit is ignored
    clr_mon(); mode = 2;
    accept(24'h000003);
    wait_end(2000, k);
    chk("t4_latency", 32'(k), 32'd1005);
    chk("t4_erro", 32'(erro), 32'd1);
    chk("t4_pend", 32'(moedas_pendentes), 32'h000003);
    chk("t4_order", 32'(order), 32'h001);
    step();

    // 5: sensor in the 2nd pulse clock ends the pulse early
    clr_mon(); mode = 3;
    accept(24'h000200);
    wait_end(200, k);
    chk("t5_latency", 32'(k), 32'd7);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_valor", 32'(valor_entregue), 32'd100);
    chk("t5_pend", 32'(moedas_pendentes), 32'd0);
    chk("t5_hop_cycles", 32'(hop_cycles), 32'd4);
    chk("t5_order", 32'(order), 32'h012);
    step();

    // 6: reset mid-pulse, then a fresh request; busy req_valid ignored
    clr_mon(); mode = 0;
    accept(24'h030000);
    step();
    chk("t6_pulsing", 32'(hopper_pulso), 32'd4);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_hopper", 32'(hopper_pulso), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd1);
    chk("t6_rst_pend", 32'(moedas_pendentes), 32'd0);
    chk("t6_rst_valor", 32'(valor_entregue), 32'd0);
    chk("t6_rst_done_erro", {30'd0, done, erro}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    chk("t6_no_pulses", 32'(done_cnt + erro_cnt), 32'd0);
    clr_mon(); mode = 1;
    accept(24'h000001);
    req_valid = 1'b1; req_moedas = 24'h000500;
    wait_end(200, k);
    req_valid = 1'b0;
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_valor", 32'(valor_entregue), 32'd25);
    chk("t6_pend", 32'(moedas_pendentes), 32'd0);
    chk("t6_order", 32'(order), 32'h001);
    step();
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    chk("t6_ready_after", 32'(req_ready), 32'd1);
    step(); step();
    chk("t6_no_late_accept", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
